wb_arbiter: RTL and testbench

//  Write-back arbiter and scoreboard: the single writer of the register file write port (rd_addr/rd_data/rd_wren).

---
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and long-path results, issue/decode scoreboard queries,
// and the register file write port.
interface wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             lp_valid;
    logic             lp_ready;
    logic [4:0]       lp_rd;
    logic [31:0]      lp_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic             busy_rs1;
    logic             busy_rs2;
    logic             busy_rd;
    logic             alu_hold;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_data;
    logic             rd_wren;
    logic [CNT_W-1:0] fifo_count;
    logic             err;

    modport master (
        output alu_valid, alu_rd, alu_data, lp_valid, lp_rd, lp_data,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  lp_ready, busy_rs1, busy_rs2, busy_rd, alu_hold,
               rd_addr, rd_data, rd_wren, fifo_count, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lp_valid, lp_rd, lp_data,
               issue_valid, issue_rd, rs1_addr, rs2_addr,
        output lp_ready, busy_rs1, busy_rs2, busy_rd, alu_hold,
               rd_addr, rd_data, rd_wren, fifo_count, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole owner of the register file write port, merging ALU results with
// buffered long-latency results, plus a pending-write scoreboard and starvation bound.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic         i_clk,
    input logic         i_reset,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      sb_q, sb_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             err_q, err_d;

    wb_entry_t        head_c;
    logic             empty_c, full_c, hold_c, alu_sel_c, push_c, pop_c;

    // Arbitration: ALU wins unless held; otherwise the FIFO head drains.
    always_comb begin
        head_c    = fifo_q[head_q];
        empty_c   = (count_q == '0);
        full_c    = (count_q == CNT_W'(DEPTH));
        hold_c    = (starve_q == SC_W'(STARVE_LIMIT));
        alu_sel_c = bus.alu_valid && !hold_c;
        pop_c     = !alu_sel_c && !empty_c;
        push_c    = bus.lp_valid && !full_c;
    end

    // Write port mux; rd=0 results still consume their slot but never write.
    always_comb begin
        bus.rd_addr = '0;
        bus.rd_data = '0;
        if (alu_sel_c) begin
            bus.rd_addr = bus.alu_rd;
            bus.rd_data = bus.alu_data;
        end else if (!empty_c) begin
            bus.rd_addr = head_c.rd;
            bus.rd_data = head_c.data;
        end
        bus.rd_wren    = (alu_sel_c || !empty_c) && (bus.rd_addr != 5'd0);
        bus.lp_ready   = !full_c;
        bus.alu_hold   = hold_c;
        bus.busy_rs1   = sb_q[bus.rs1_addr];
        bus.busy_rs2   = sb_q[bus.rs2_addr];
        bus.busy_rd    = sb_q[bus.issue_rd];
        bus.fifo_count = count_q;
        bus.err        = err_q;
    end

    // Next-state: pointers, occupancy, scoreboard, starvation counter, sticky error.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_c) tail_d = tail_q + PTR_W'(1);
        if (pop_c)  head_d = head_q + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A clear and a set of the same register in one cycle leaves it set.
        sb_d = sb_q;
        if (pop_c) sb_d[head_c.rd] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) sb_d[bus.issue_rd] = 1'b1;
        sb_d[0] = 1'b0;

        starve_d = starve_q;
        if (pop_c || empty_c) starve_d = '0;
        else if (alu_sel_c)   starve_d = starve_q + SC_W'(1);

        err_d = err_q
              | (bus.alu_valid && hold_c)
              | (alu_sel_c && (bus.alu_rd != 5'd0) && sb_q[bus.alu_rd])
              | (bus.issue_valid && sb_q[bus.issue_rd]);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            sb_q     <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            sb_q     <= sb_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push_c) fifo_q[tail_q] <= '{rd: bus.lp_rd, data: bus.lp_data};
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with constant expectations, then random traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 4;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference model state: pending results in arrival order, set of registers awaiting
    // a long-latency result, run of ALU wins over a waiting FIFO, sticky error.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t      mq[$];
    bit [31:0] m_sb;
    int        m_wins;
    bit        m_err;

    // {wren, addr, data, lp_ready, hold, busy_rs1, busy_rs2, busy_rd, count, err}
    function automatic logic [46:0] obs();
        return {bus.rd_wren, bus.rd_addr, bus.rd_data, bus.lp_ready, bus.alu_hold,
                bus.busy_rs1, bus.busy_rs2, bus.busy_rd, bus.fifo_count, bus.err};
    endfunction

    function automatic logic [46:0] model_expect();
        bit          hold      = (m_wins == STARVE_LIMIT);
        bit          alu_takes = bus.alu_valid && !hold;
        bit          fifo_src  = !alu_takes && (mq.size() != 0);
        logic [4:0]  a = 5'd0;
        logic [31:0] d = 32'd0;
        if (alu_takes) begin a = bus.alu_rd; d = bus.alu_data; end
        else if (fifo_src) begin a = mq[0].rd; d = mq[0].data; end
        return {((alu_takes || fifo_src) && a != 5'd0), a, d, (mq.size() < DEPTH), hold,
                m_sb[bus.rs1_addr], m_sb[bus.rs2_addr], m_sb[bus.issue_rd],
                3'(mq.size()), m_err};
    endfunction

    task automatic model_commit();
        bit   hold      = (m_wins == STARVE_LIMIT);
        bit   alu_takes = bus.alu_valid && !hold;
        bit   fifo_src  = !alu_takes && (mq.size() != 0);
        bit   accept    = bus.lp_valid && (mq.size() < DEPTH);
        ent_t e;
        if (bus.alu_valid && hold) m_err = 1;
        if (alu_takes && bus.alu_rd != 0 && m_sb[bus.alu_rd]) m_err = 1;
        if (bus.issue_valid && m_sb[bus.issue_rd]) m_err = 1;
        if (fifo_src) m_sb[mq[0].rd] = 0;
        if (bus.issue_valid && bus.issue_rd != 0) m_sb[bus.issue_rd] = 1;
        if (fifo_src || mq.size() == 0) m_wins = 0;
        else if (alu_takes) m_wins++;
        if (fifo_src) void'(mq.pop_front());
        if (accept) begin
            e.rd = bus.lp_rd; e.data = bus.lp_data;
            mq.push_back(e);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lp_valid = 0; bus.lp_rd = 0; bus.lp_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
    endtask

    task automatic clk_step();
        @(posedge i_clk); #1;
    endtask

    task automatic apply_reset();
        idle();
        i_reset = 0;
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 1;
        clk_step();
        mq.delete(); m_sb = 0; m_wins = 0; m_err = 0;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 0;
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++;
        if (obs() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs(),
                               {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0});
        end
        apply_reset();
        n_checks++;
        if ({bus.rd_wren, bus.lp_ready, bus.fifo_count, bus.err} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_release: got %b%b%0d%b want 0100", bus.rd_wren,
                               bus.lp_ready, bus.fifo_count, bus.err);
        end
    endtask

    task automatic test_long_path();
        apply_reset();
        bus.issue_valid = 1; bus.issue_rd = 5; bus.rs1_addr = 5;
        clk_step();
        bus.issue_valid = 0;
        bus.lp_valid = 1; bus.lp_rd = 5; bus.lp_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({bus.busy_rs1, bus.rd_wren} !== 2'b10) begin
            n_fail++; $display("FAIL lp_busy_no_bypass: got busy=%b wren=%b want busy=1 wren=0",
                               bus.busy_rs1, bus.rd_wren);
        end
        clk_step();
        bus.lp_valid = 0;
        #1;
        n_checks++;
        if ({bus.rd_wren, bus.rd_addr, bus.rd_data, bus.fifo_count, bus.busy_rs1} !==
            {1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1}) begin
            n_fail++; $display("FAIL lp_write: got wren=%b addr=%0d data=%h cnt=%0d busy=%b want 1 5 deadbeef 1 1",
                               bus.rd_wren, bus.rd_addr, bus.rd_data, bus.fifo_count, bus.busy_rs1);
        end
        clk_step();
        n_checks++;
        if ({bus.busy_rs1, bus.rd_wren, bus.fifo_count} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL lp_after_pop: got busy=%b wren=%b cnt=%0d want 0 0 0",
                               bus.busy_rs1, bus.rd_wren, bus.fifo_count);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hA5A50000;
        for (int i = 0; i < 4; i++) begin
            bus.lp_valid = 1; bus.lp_rd = 5'(i + 1); bus.lp_data = 32'h1000 + 32'(i);
            #1;
            n_checks++;
            if ({bus.rd_wren, bus.rd_addr, bus.rd_data} !== {1'b1, 5'd3, 32'hA5A50000}) begin
                n_fail++; $display("FAIL fill_alu_wins[%0d]: got wren=%b addr=%0d want 1 3", i,
                                   bus.rd_wren, bus.rd_addr);
            end
            clk_step();
        end
        bus.lp_rd = 5'd9; bus.lp_data = 32'hBAD;
        #1;
        n_checks++;
        if ({bus.fifo_count, bus.lp_ready, bus.alu_hold} !== {3'd4, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL fill_full: got cnt=%0d ready=%b hold=%b want 4 0 0",
                               bus.fifo_count, bus.lp_ready, bus.alu_hold);
        end
        clk_step();
        bus.lp_valid = 0; bus.alu_valid = 0;
        #1;
        n_checks++;
        if ({bus.fifo_count, bus.lp_ready, bus.alu_hold, bus.rd_wren, bus.rd_addr, bus.rd_data} !==
            {3'd4, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1000}) begin
            n_fail++; $display("FAIL fill_hold_pop: got cnt=%0d ready=%b hold=%b wren=%b addr=%0d data=%h want 4 0 1 1 1 1000",
                               bus.fifo_count, bus.lp_ready, bus.alu_hold, bus.rd_wren,
                               bus.rd_addr, bus.rd_data);
        end
        clk_step();
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if ({bus.rd_wren, bus.rd_addr, bus.rd_data} !== {1'b1, 5'(i + 1), 32'h1000 + 32'(i)}) begin
                n_fail++; $display("FAIL fill_drain[%0d]: got wren=%b addr=%0d data=%h want 1 %0d %h", i,
                                   bus.rd_wren, bus.rd_addr, bus.rd_data, i + 1, 32'h1000 + 32'(i));
            end
            clk_step();
        end
        n_checks++;
        if ({bus.fifo_count, bus.rd_wren, bus.err} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL fill_empty: got cnt=%0d wren=%b err=%b want 0 0 0",
                               bus.fifo_count, bus.rd_wren, bus.err);
        end
    endtask

    task automatic test_starvation();
        apply_reset();
        bus.lp_valid = 1; bus.lp_rd = 9; bus.lp_data = 32'h99;
        clk_step();
        bus.lp_valid = 0;
        bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h22;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++;
            if ({bus.alu_hold, bus.rd_wren, bus.rd_addr} !== {1'b0, 1'b1, 5'd2}) begin
                n_fail++; $display("FAIL starve_alu[%0d]: got hold=%b wren=%b addr=%0d want 0 1 2", c,
                                   bus.alu_hold, bus.rd_wren, bus.rd_addr);
            end
            clk_step();
        end
        #1;
        n_checks++;
        if ({bus.alu_hold, bus.rd_wren, bus.rd_addr, bus.rd_data, bus.fifo_count} !==
            {1'b1, 1'b1, 5'd9, 32'h99, 3'd1}) begin
            n_fail++; $display("FAIL starve_hold: got hold=%b wren=%b addr=%0d data=%h cnt=%0d want 1 1 9 99 1",
                               bus.alu_hold, bus.rd_wren, bus.rd_addr, bus.rd_data, bus.fifo_count);
        end
        clk_step();
        bus.alu_valid = 0;
        n_checks++;
        if ({bus.alu_hold, bus.fifo_count, bus.err} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL starve_after: got hold=%b cnt=%0d err=%b want 0 0 1",
                               bus.alu_hold, bus.fifo_count, bus.err);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        bus.issue_valid = 1; bus.issue_rd = 0;
        clk_step();
        bus.issue_valid = 0;
        bus.lp_valid = 1; bus.lp_rd = 0; bus.lp_data = 32'h1234;
        clk_step();
        bus.lp_valid = 0;
        #1;
        n_checks++;
        if ({bus.fifo_count, bus.rd_wren, bus.rd_addr, bus.busy_rs1, bus.busy_rd, bus.err} !==
            {3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL x0_entry: got cnt=%0d wren=%b addr=%0d busy=%b%b err=%b want 1 0 0 00 0",
                               bus.fifo_count, bus.rd_wren, bus.rd_addr, bus.busy_rs1,
                               bus.busy_rd, bus.err);
        end
        clk_step();
        n_checks++;
        if (bus.fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL x0_popped: got cnt=%0d want 0", bus.fifo_count);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        bus.issue_valid = 1; bus.issue_rd = 7;
        clk_step();
        bus.issue_valid = 0;
        #1;
        n_checks++;
        if ({bus.busy_rd, bus.err} !== 2'b10) begin
            n_fail++; $display("FAIL err_waw_check: got busy_rd=%b err=%b want 1 0", bus.busy_rd, bus.err);
        end
        bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h7;
        clk_step();
        bus.alu_valid = 0;
        repeat (3) clk_step();
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL err_raw_sticky: got %b want 1", bus.err);
        end
        apply_reset();
        bus.rs2_addr = 12;
        bus.issue_valid = 1; bus.issue_rd = 12;
        clk_step();
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL err_first_issue: got %b want 0", bus.err);
        end
        clk_step();
        bus.issue_valid = 0;
        n_checks++;
        if ({bus.err, bus.busy_rs2} !== 2'b11) begin
            n_fail++; $display("FAIL err_waw_issue: got err=%b busy=%b want 1 1", bus.err, bus.busy_rs2);
        end
    endtask

    task automatic test_random();
        logic [46:0] exp_v;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) apply_reset();
            bus.alu_valid   = ($urandom_range(0, 99) < 50);
            bus.alu_rd      = 5'($urandom_range(0, 7));
            bus.alu_data    = $urandom();
            bus.lp_valid    = ($urandom_range(0, 99) < 45);
            bus.lp_rd       = 5'($urandom_range(0, 7));
            bus.lp_data     = $urandom();
            bus.issue_valid = ($urandom_range(0, 99) < 20);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.rs1_addr    = 5'($urandom_range(0, 7));
            bus.rs2_addr    = 5'($urandom_range(0, 7));
            #1;
            exp_v = model_expect();
            n_checks++;
            if (obs() !== exp_v) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", cyc, obs(), exp_v);
            end
            @(posedge i_clk);
            model_commit();
            #1;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.rs1_addr = 4;
        bus.issue_valid = 1; bus.issue_rd = 4;
        bus.lp_valid = 1; bus.lp_rd = 4; bus.lp_data = 32'h44;
        clk_step();
        bus.lp_rd = 6; bus.lp_data = 32'h66;
        clk_step();
        n_checks++;
        if ({bus.err, bus.fifo_count, bus.busy_rs1} !== {1'b1, 3'd1, 1'b1}) begin
            n_fail++; $display("FAIL mid_pre_reset: got err=%b cnt=%0d busy=%b want 1 1 1",
                               bus.err, bus.fifo_count, bus.busy_rs1);
        end
        #2;
        i_reset = 0;
        #1;
        n_checks++;
        if (obs() !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL mid_async_reset: got %h want %h", obs(),
                               {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 3'b000, 3'd0, 1'b0});
        end
        idle();
        @(negedge i_clk);
        i_reset = 1;
        clk_step();
    endtask

    initial begin
        test_reset();
        test_long_path();
        test_fill();
        test_starvation();
        test_x0();
        test_errors();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
